// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, colour and sync-bundle types,
// and the colour-bar lookup used by the optional test pattern
// (VGA_TEST_PATTERN_EN).
package vga_timing_pkg;

  // Horizontal timing in pixels, vertical timing in lines.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Derived frame geometry; sync windows are [START, END).
  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // 12-bit colour {R[11:8], G[7:4], B[3:0]}.
  typedef logic [11:0] colour_t;

  // One slot of the sync delay line. Syncs are active-low.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Idle value: syncs inactive, video blanked.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

  // Eight vertical colour bars across the active width.
  localparam int unsigned BAR_WIDTH = 80;
  localparam int unsigned BAR_COUNT = 8;
  localparam colour_t BAR_COLOURS [BAR_COUNT] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Colour of the bar covering column hpos; columns past the last bar
  // reuse the last colour (they are blanked anyway).
  function automatic colour_t test_bar_colour(input int unsigned hpos);
    int unsigned idx;
    idx = hpos / BAR_WIDTH;
    if (idx > BAR_COUNT - 1) begin
      idx = BAR_COUNT - 1;
    end
    return BAR_COLOURS[idx[2:0]];
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bus between the timing source (master) and
// the renderers/display pins (slave). test_mode exists only when
// VGA_TEST_PATTERN_EN is defined.
interface vga_timing_if #(
  parameter int WIDTH = 10
);

  logic                     pixel_tick;
  logic [WIDTH-1:0]         hor_pix;
  logic [WIDTH-1:0]         ver_pix;
  logic                     video_on;
  logic                     frame_completed;
  logic                     HS;
  logic                     VS;
  vga_timing_pkg::colour_t  vgaRGB;
  vga_timing_pkg::colour_t  rgb_in;
`ifdef VGA_TEST_PATTERN_EN
  logic                     test_mode;
`endif

  modport master (
    output pixel_tick, hor_pix, ver_pix, video_on, frame_completed,
    output HS, VS, vgaRGB,
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  rgb_in
  );

  modport slave (
    input  pixel_tick, hor_pix, ver_pix, video_on, frame_completed,
    input  HS, VS, vgaRGB,
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    output rgb_in
  );

endinterface

// File: rtl/pixel_ce_gen.sv
// pixel_ce_gen: divides the system clock by CLK_DIV into a registered
// one-clock pixel enable. The first pulse appears CLK_DIV clocks after reset
// release.
module pixel_ce_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  // Next count and tick: the tick is raised in the same clock the count wraps.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider count and registered tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign pixel_tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing source. Produces the pixel enable,
// hor/ver counters, video_on and a per-frame strobe, then delays sync and
// blanking by SYNC_DELAY pixel ticks (0..7) so they line up with the
// renderer's pipelined colour. Optional test bars under VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_DELAY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;

  // Counter-width constants; all comparisons are unsigned WIDTH-bit.
  localparam logic [WIDTH-1:0] H_LAST    = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] V_LAST    = WIDTH'(V_TOTAL - 1);
  localparam logic [WIDTH-1:0] H_ACT_END = WIDTH'(H_ACTIVE);
  localparam logic [WIDTH-1:0] V_ACT_END = WIDTH'(V_ACTIVE);
  localparam logic [WIDTH-1:0] V_ACT_LST = WIDTH'(V_ACTIVE - 1);
  localparam logic [WIDTH-1:0] HS_START  = WIDTH'(H_SYNC_START);
  localparam logic [WIDTH-1:0] HS_END    = WIDTH'(H_SYNC_START + H_SYNC);
  localparam logic [WIDTH-1:0] VS_START  = WIDTH'(V_SYNC_START);
  localparam logic [WIDTH-1:0] VS_END    = WIDTH'(V_SYNC_START + V_SYNC);

  logic             pixel_tick;
  logic [WIDTH-1:0] hor_q, hor_d;
  logic [WIDTH-1:0] ver_q, ver_d;
  logic             video_q, video_d;
  logic             frame_q, frame_d;
  sync_t            raw_d;
  sync_t            dly;
  logic             hs_q, vs_q;
  colour_t          rgb_q, rgb_d;
`ifdef VGA_TEST_PATTERN_EN
  logic [WIDTH-1:0] dly_hpos;
`endif

  pixel_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_ce (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_tick_o (pixel_tick)
  );

  // Next counter position and everything derived from it. Sync/blank are
  // taken from the next position so that SYNC_DELAY = 0 puts HS/VS exactly
  // in step with the counters.
  always_comb begin
    hor_d   = hor_q;
    ver_d   = ver_q;
    frame_d = 1'b0;
    raw_d   = SYNC_IDLE;
    if (pixel_tick) begin
      if (hor_q == H_LAST) begin
        hor_d = '0;
        ver_d = (ver_q == V_LAST) ? '0 : ver_q + 1'b1;
      end else begin
        hor_d = hor_q + 1'b1;
      end
      // Only on a tick, so a held (last col, last active row) never repeats.
      frame_d = (hor_d == H_LAST) && (ver_d == V_ACT_LST);
    end
    video_d     = (hor_d < H_ACT_END) && (ver_d < V_ACT_END);
    raw_d.hs    = !((hor_d >= HS_START) && (hor_d < HS_END));
    raw_d.vs    = !((ver_d >= VS_START) && (ver_d < VS_END));
    raw_d.blank = !video_d;
  end

  // Counter, video_on and frame-strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hor_q   <= '0;
      ver_q   <= '0;
      video_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hor_q   <= hor_d;
      ver_q   <= ver_d;
      frame_q <= frame_d;
      if (pixel_tick) begin
        video_q <= video_d;
      end
    end
  end

  genvar gi;
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign dly = raw_d;
`ifdef VGA_TEST_PATTERN_EN
      assign dly_hpos = hor_d;
`endif
    end else begin : g_delay
      for (gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
        sync_t stage_q;
        sync_t stage_d;
`ifdef VGA_TEST_PATTERN_EN
        logic [WIDTH-1:0] hpos_q;
        logic [WIDTH-1:0] hpos_d;
`endif
        if (gi == 0) begin : g_head
          assign stage_d = raw_d;
`ifdef VGA_TEST_PATTERN_EN
          assign hpos_d = hor_d;
`endif
        end else begin : g_link
          assign stage_d = g_stage[gi-1].stage_q;
`ifdef VGA_TEST_PATTERN_EN
          assign hpos_d = g_stage[gi-1].hpos_q;
`endif
        end

        // One pixel of delay; reset fills the line with idle syncs and blank.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            stage_q <= SYNC_IDLE;
`ifdef VGA_TEST_PATTERN_EN
            hpos_q  <= '0;
`endif
          end else if (pixel_tick) begin
            stage_q <= stage_d;
`ifdef VGA_TEST_PATTERN_EN
            hpos_q  <= hpos_d;
`endif
          end
        end
      end
      assign dly = g_stage[SYNC_DELAY-1].stage_q;
`ifdef VGA_TEST_PATTERN_EN
      assign dly_hpos = g_stage[SYNC_DELAY-1].hpos_q;
`endif
    end
  endgenerate

  // Colour source selection and blanking against the delayed position.
  always_comb begin
    rgb_d = vga.rgb_in;
`ifdef VGA_TEST_PATTERN_EN
    if (vga.test_mode) begin
      rgb_d = test_bar_colour(32'(dly_hpos));
    end
`endif
    if (dly.blank) begin
      rgb_d = '0;
    end
  end

  // Output flops: every pin comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else if (pixel_tick) begin
      hs_q  <= dly.hs;
      vs_q  <= dly.vs;
      rgb_q <= rgb_d;
    end
  end

  assign vga.pixel_tick      = pixel_tick;
  assign vga.hor_pix         = hor_q;
  assign vga.ver_pix         = ver_q;
  assign vga.video_on        = video_q;
  assign vga.frame_completed = frame_q;
  assign vga.HS              = hs_q;
  assign vga.VS              = vs_q;
  assign vga.vgaRGB          = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench. u_big runs the real 640x480 geometry
// (CLK_DIV=4, SYNC_DELAY=2) for horizontal checks; u_sml uses a 16x13 raster
// (CLK_DIV=2, SYNC_DELAY=1) so vertical wrap, VS and frame strobes fit in a
// short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vga_timing_if #(.WIDTH(10)) big_if ();
  vga_timing_if #(.WIDTH(10)) sml_if ();

  vga_timing_gen #(
    .WIDTH(10), .CLK_DIV(4), .SYNC_DELAY(2)
  ) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (big_if)
  );

  vga_timing_gen #(
    .WIDTH(10), .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(1)
  ) u_sml (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (sml_if)
  );

  int checks = 0;
  int errors = 0;
  int e      = 0;   // clock edges since the last reset release

  // Tallies for the loop phases.
  int n;
  int rgb_nz, rgb_bad, hs_low, hs_first, vs_low, vs_first, von;
  int tick_cnt, fc_cnt, fc_bad, fc_first, wrap_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic go(input int target);
    while (e < target) step();
  endtask

  initial begin
    big_if.rgb_in = 12'hA0A;
    sml_if.rgb_in = 12'h5C3;
`ifdef VGA_TEST_PATTERN_EN
    big_if.test_mode = 1'b0;
    sml_if.test_mode = 1'b0;
`endif

    // ---- reset values ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick",  big_if.pixel_tick, 0);
    chk("rst_hor",   big_if.hor_pix, 0);
    chk("rst_ver",   big_if.ver_pix, 0);
    chk("rst_von",   big_if.video_on, 0);
    chk("rst_fc",    big_if.frame_completed, 0);
    chk("rst_hs",    big_if.HS, 1);
    chk("rst_vs",    big_if.VS, 1);
    chk("rst_rgb",   big_if.vgaRGB, 0);
    $display("step: reset values checked");

    // ---- release and first ticks ----
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("big_tick_edge", big_if.pixel_tick, (k == 4));
      chk("sml_tick_edge", sml_if.pixel_tick, (k % 2 == 0));
    end
    chk("big_hor_first", big_if.hor_pix, 1);
    chk("big_ver_first", big_if.ver_pix, 0);
    chk("big_von_first", big_if.video_on, 1);
    chk("sml_hor_first", sml_if.hor_pix, 2);
    $display("step: first pixel ticks checked");

    // ---- big: horizontal sync and wrap (tick n sampled at edge 4n+1) ----
    go(4*655+1); chk("big_hor_655", big_if.hor_pix, 655);
    go(4*656+1); chk("big_hor_656", big_if.hor_pix, 656);
                 chk("big_von_656", big_if.video_on, 0);
                 chk("big_hs_656",  big_if.HS, 1);
    go(4*657+1); chk("big_hs_657",  big_if.HS, 1);
    go(4*658+1); chk("big_hs_658",  big_if.HS, 0);
    go(4*753+1); chk("big_hs_753",  big_if.HS, 0);
    go(4*754+1); chk("big_hs_754",  big_if.HS, 1);
    go(4*799+1); chk("big_hor_799", big_if.hor_pix, 799);
                 chk("big_ver_799", big_if.ver_pix, 0);
                 chk("big_fc_799",  big_if.frame_completed, 0);
    go(4*800+1); chk("big_hor_wrap", big_if.hor_pix, 0);
                 chk("big_ver_inc",  big_if.ver_pix, 1);
    $display("step: big line 0 sync and wrap checked");

    // ---- big: full line 1 statistics ----
    rgb_nz = 0; rgb_bad = 0; hs_low = 0; hs_first = 0; vs_low = 0; von = 0;
    for (int t = 800; t < 1600; t++) begin
      go(4*t+1);
      if (big_if.vgaRGB != 12'h000) rgb_nz++;
      if (big_if.vgaRGB != 12'h000 && big_if.vgaRGB != 12'hA0A) rgb_bad++;
      if (big_if.HS == 1'b0) begin
        hs_low++;
        if (hs_first == 0) hs_first = t;
      end
      if (big_if.VS == 1'b0) vs_low++;
      if (big_if.video_on) von++;
    end
    chk("big_rgb_active_cnt", rgb_nz, 640);
    chk("big_rgb_value_bad",  rgb_bad, 0);
    chk("big_hs_low_cnt",     hs_low, 96);
    chk("big_hs_first_tick",  hs_first, 1458);
    chk("big_vs_low_cnt",     vs_low, 0);
    chk("big_von_cnt",        von, 640);
    $display("step: big line 1 statistics checked");

    // ---- big: asynchronous reset while HS is low ----
    go(4*2258+1);
    chk("big_hs_pre_rst", big_if.HS, 0);
    chk("big_ver_pre_rst", big_if.ver_pix, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("big_async_hs",  big_if.HS, 1);
    chk("big_async_hor", big_if.hor_pix, 0);
    chk("big_async_ver", big_if.ver_pix, 0);
    $display("step: big asynchronous reset checked");

    // ---- small: two full frames, sampled every clock ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    rgb_nz = 0; rgb_bad = 0; hs_low = 0; vs_low = 0; vs_first = 0; von = 0;
    tick_cnt = 0; fc_cnt = 0; fc_bad = 0; fc_first = 0; wrap_first = 0;
    while (e < 833) begin
      step();
      if (sml_if.pixel_tick) tick_cnt++;
      if (sml_if.frame_completed) begin
        fc_cnt++;
        if (sml_if.hor_pix != 10'd15 || sml_if.ver_pix != 10'd5) fc_bad++;
        if (fc_first == 0) fc_first = e;
      end
      if (e % 2 == 1 && e >= 3) begin
        n = (e - 1) / 2;
        if (sml_if.hor_pix == 10'd0 && sml_if.ver_pix == 10'd0 && wrap_first == 0) wrap_first = e;
        if (sml_if.VS == 1'b0) begin
          vs_low++;
          if (vs_first == 0) vs_first = n;
        end
        if (sml_if.HS == 1'b0) hs_low++;
        if (sml_if.vgaRGB != 12'h000) rgb_nz++;
        if (sml_if.vgaRGB != 12'h000 && sml_if.vgaRGB != 12'h5C3) rgb_bad++;
        if (sml_if.video_on) von++;
      end
    end
    chk("sml_tick_cnt",    tick_cnt, 416);
    chk("sml_fc_cnt",      fc_cnt, 2);
    chk("sml_fc_pos_bad",  fc_bad, 0);
    chk("sml_fc_first",    fc_first, 191);
    chk("sml_wrap_edge",   wrap_first, 417);
    chk("sml_vs_first",    vs_first, 129);
    chk("sml_vs_low_cnt",  vs_low, 64);
    chk("sml_hs_low_cnt",  hs_low, 78);
    chk("sml_rgb_nz_cnt",  rgb_nz, 95);
    chk("sml_rgb_bad",     rgb_bad, 0);
    chk("sml_von_cnt",     von, 96);
    $display("step: small two-frame statistics checked");

    // ---- small: mid-frame reset during VS ----
    go(2*485+1);
    chk("sml_rgb_mid",   sml_if.vgaRGB, 12'h5C3);
    chk("sml_von_mid",   sml_if.video_on, 1);
    go(2*549+1);
    chk("sml_hor_pre",   sml_if.hor_pix, 5);
    chk("sml_ver_pre",   sml_if.ver_pix, 8);
    chk("sml_vs_pre",    sml_if.VS, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("sml_async_hor", sml_if.hor_pix, 0);
    chk("sml_async_ver", sml_if.ver_pix, 0);
    chk("sml_async_vs",  sml_if.VS, 1);
    chk("sml_async_rgb", sml_if.vgaRGB, 0);
    chk("sml_async_von", sml_if.video_on, 0);
    $display("step: small mid-frame reset checked");

    // ---- small: restart timing after release ----
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    go(3);  chk("sml_restart_hor", sml_if.hor_pix, 1);
            chk("sml_restart_ver", sml_if.ver_pix, 0);
            chk("sml_restart_vs",  sml_if.VS, 1);
    go(21); chk("sml_restart_hs10", sml_if.HS, 1);
    go(23); chk("sml_restart_hs11", sml_if.HS, 0);
    go(27); chk("sml_restart_hs13", sml_if.HS, 0);
    go(29); chk("sml_restart_hs14", sml_if.HS, 1);
    $display("step: small restart timing checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
